// File: rtl/vend_coin_feeder.sv
// rtl/vend_coin_feeder.sv - coin feeder that pays a vending machine item by item (optional: FEEDER_CHANGE_CHECK_EN)
module vend_coin_feeder #(
    parameter int SEL_SETUP = 2,
    parameter int COIN_GAP  = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [2:0] i_req_sel,
    input  logic       i_req_overpay,
    output logic [2:0] o_sel,
    output logic       o_coin_5,
    output logic       o_coin_10,
    input  logic       i_dispense,
    input  logic       i_change_5,
    output logic       o_done,
    output logic       o_change_seen,
    output logic       o_timeout_err,
    output logic       o_bad_sel,
    output logic       o_change_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_COIN  = 3'd2,
        S_GAP   = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Last count value of each timed state. WAIT is entered the cycle the last
    // coin becomes visible, so TIMEOUT-1 WAIT cycles plus the DONE cycle place
    // the done pulse exactly TIMEOUT cycles after the last coin.
    localparam logic [7:0] SETUP_LAST = (SEL_SETUP >= 1) ? 8'(SEL_SETUP - 1) : 8'd0;
    localparam logic [7:0] GAP_LAST   = (COIN_GAP  >= 1) ? 8'(COIN_GAP - 1)  : 8'd0;
    localparam logic [7:0] WAIT_LAST  = (TIMEOUT   >= 2) ? 8'(TIMEOUT - 2)   : 8'd0;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic [3:0] r_rem;
    logic       r_bad;
    logic       r_tmo;

    logic       w_accept;
    logic       w_sel_bad;
    logic [3:0] w_rem_after;
    logic       w_setup_end;
    logic       w_gap_end;
    logic       w_wait_end;

    logic [2:0] w_sel_d;
    logic       w_req_ready_d;
    logic       w_coin_5_d;
    logic       w_coin_10_d;
    logic       w_done_d;
    logic       w_change_seen_d;
    logic       w_timeout_err_d;
    logic       w_bad_sel_d;
    logic       w_change_err_d;

`ifdef FEEDER_CHANGE_CHECK_EN
    logic       r_ovp;
    logic       w_change_final;
`endif

    assign w_accept    = i_req_valid & o_req_ready;
    assign w_sel_bad   = (i_req_sel > 3'd4);
    // Odd remainder pays the 5 first so the final coin always crosses the price.
    assign w_rem_after = r_rem[0] ? (r_rem - 4'd1) : (r_rem - 4'd2);
    assign w_setup_end = (r_cnt >= SETUP_LAST);
    assign w_gap_end   = (r_cnt >= GAP_LAST);
    assign w_wait_end  = (r_cnt >= WAIT_LAST);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; a dispense ends payment immediately and beats a timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_sel_bad ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_setup_end) begin
                    w_next = S_COIN;
                end
            end
            S_COIN: begin
                if (i_dispense) begin
                    w_next = S_DONE;
                end else if (w_rem_after == 4'd0) begin
                    w_next = S_WAIT;
                end else if (COIN_GAP == 0) begin
                    w_next = S_COIN;
                end else begin
                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                if (i_dispense) begin
                    w_next = S_DONE;
                end else if (w_gap_end) begin
                    w_next = S_COIN;
                end
            end
            S_WAIT: begin
                if (i_dispense || w_wait_end) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Per-state cycle counter, restarted on every state change
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 8'd0;
        end else if ((w_next != r_state) || (r_state == S_IDLE)) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Transaction context: remaining 5-unit coins and pending error flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem <= 4'd0;
            r_bad <= 1'b0;
            r_tmo <= 1'b0;
        end else if (w_accept) begin
            r_rem <= 4'd2 + {1'b0, i_req_sel} + {3'b000, i_req_overpay};
            r_bad <= w_sel_bad;
            r_tmo <= 1'b0;
        end else begin
            if (r_state == S_COIN) begin
                r_rem <= w_rem_after;
            end
            if ((r_state == S_WAIT) && !i_dispense && w_wait_end) begin
                r_tmo <= 1'b1;
            end
        end
    end

`ifdef FEEDER_CHANGE_CHECK_EN
    // Pay mode latched for the change compare at completion
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovp <= 1'b0;
        end else if (w_accept) begin
            r_ovp <= i_req_overpay;
        end
    end

    assign w_change_final = o_change_seen | i_change_5;
`endif

    // Output decode: next value of every registered output
    always_comb begin
        w_req_ready_d   = (w_next == S_IDLE);
        w_sel_d         = (w_accept && !w_sel_bad) ? i_req_sel : o_sel;
        w_coin_5_d      = (r_state == S_COIN) &&  r_rem[0];
        w_coin_10_d     = (r_state == S_COIN) && !r_rem[0];
        w_done_d        = (r_state == S_DONE);
        w_change_seen_d = o_change_seen;
        w_timeout_err_d = o_timeout_err;
        w_bad_sel_d     = o_bad_sel;
        w_change_err_d  = o_change_err;
        if (w_accept) begin
            w_change_seen_d = 1'b0;
            w_timeout_err_d = 1'b0;
            w_bad_sel_d     = 1'b0;
            w_change_err_d  = 1'b0;
        end else begin
            if (r_state != S_IDLE) begin
                w_change_seen_d = o_change_seen | i_change_5;
            end
            if (r_state == S_DONE) begin
                w_timeout_err_d = r_tmo;
                w_bad_sel_d     = r_bad;
`ifdef FEEDER_CHANGE_CHECK_EN
                w_change_err_d  = (w_change_final != r_ovp) && !r_bad && !r_tmo;
`else
                w_change_err_d  = 1'b0;
`endif
            end
        end
    end

    // Output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_req_ready   <= 1'b1;
            o_sel         <= 3'd0;
            o_coin_5      <= 1'b0;
            o_coin_10     <= 1'b0;
            o_done        <= 1'b0;
            o_change_seen <= 1'b0;
            o_timeout_err <= 1'b0;
            o_bad_sel     <= 1'b0;
            o_change_err  <= 1'b0;
        end else begin
            o_req_ready   <= w_req_ready_d;
            o_sel         <= w_sel_d;
            o_coin_5      <= w_coin_5_d;
            o_coin_10     <= w_coin_10_d;
            o_done        <= w_done_d;
            o_change_seen <= w_change_seen_d;
            o_timeout_err <= w_timeout_err_d;
            o_bad_sel     <= w_bad_sel_d;
            o_change_err  <= w_change_err_d;
        end
    end

endmodule
